tft_timing_gen: RTL and testbench

TFT_TIMING_GEN -- requirements
Module: tft_timing_gen

---
 rtl/tft_timing_pkg.sv | 28 ++
 rtl/tft_axis_counter.sv | 57 +++++
 rtl/tft_timing_gen.sv | 88 ++++++++
 tb/tb_tft_timing_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tft_timing_pkg.sv
// rtl/tft_timing_pkg.sv - shared TFT panel timing constants and helpers
// Also imported by the ball and paddle renderers.
package tft_timing_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned PIX_W = 9;

    localparam int unsigned H_SYNC_DEF   = 41;
    localparam int unsigned H_BP_DEF     = 3;
    localparam int unsigned H_ACTIVE_DEF = 480;
    localparam int unsigned H_FP_DEF     = 1;
    localparam int unsigned H_TOTAL_DEF  = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned H_ACT_START_DEF = H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned H_ACT_END_DEF   = H_ACT_START_DEF + H_ACTIVE_DEF - 1;

    localparam int unsigned V_SYNC_DEF   = 10;
    localparam int unsigned V_BP_DEF     = 3;
    localparam int unsigned V_ACTIVE_DEF = 272;
    localparam int unsigned V_FP_DEF     = 1;
    localparam int unsigned V_TOTAL_DEF  = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned V_ACT_START_DEF = V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned V_ACT_END_DEF   = V_ACT_START_DEF + V_ACTIVE_DEF - 1;

    function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/tft_axis_counter.sv
// rtl/tft_axis_counter.sv - wrap counter with carry-out and sync/active decode
// Exposes next-state values so the top can register its decodes in step with cnt.
module tft_axis_counter
    import tft_timing_pkg::*;
#(
    parameter int unsigned TOTAL     = H_TOTAL_DEF,
    parameter int unsigned SYNC      = H_SYNC_DEF,
    parameter int unsigned ACT_START = H_ACT_START_DEF,
    parameter int unsigned ACT_END   = H_ACT_END_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic             sync_n,
    output logic             carry,
    output logic             active_next,
    output logic             last_next
);

    localparam logic [CNT_W-1:0] LAST_C  = to_cnt(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_C  = to_cnt(SYNC);
    localparam logic [CNT_W-1:0] START_C = to_cnt(ACT_START);
    localparam logic [CNT_W-1:0] END_C   = to_cnt(ACT_END);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, sync_d;

    always_comb begin
        carry = step && (cnt_q == LAST_C);
        cnt_d = cnt_q;
        if (carry) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sync_d = (cnt_d >= SYNC_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt         = cnt_q;
    assign sync_n      = sync_q;
    assign cnt_next    = cnt_d;
    assign active_next = (cnt_d >= START_C) && (cnt_d <= END_C);
    assign last_next   = (cnt_d == LAST_C);

endmodule

// File: rtl/tft_timing_gen.sv
// rtl/tft_timing_gen.sv - TFT panel raster timing generator
// All outputs are registered from the same next-count so they never skew.
module tft_timing_gen
    import tft_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [PIX_W-1:0] pix_x,
    output logic [PIX_W-1:0] pix_y,
    output logic             frame_end
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_START_C = to_cnt(H_START);
    localparam logic [CNT_W-1:0] V_START_C = to_cnt(V_START);

    logic [CNT_W-1:0] h_next, v_next, h_off, v_off;
    logic             h_carry, v_carry_unused;
    logic             h_act_next, v_act_next, h_last_next, v_last_next;

    logic             de_q, de_d;
    logic [PIX_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic             frame_end_q, frame_end_d;

    tft_axis_counter #(
        .TOTAL(H_TOTAL), .SYNC(H_SYNC), .ACT_START(H_START), .ACT_END(H_START + H_ACTIVE - 1)
    ) u_h (
        .clk(clk), .rst(rst), .step(en),
        .cnt(hcnt), .cnt_next(h_next), .sync_n(hsync), .carry(h_carry),
        .active_next(h_act_next), .last_next(h_last_next)
    );

    tft_axis_counter #(
        .TOTAL(V_TOTAL), .SYNC(V_SYNC), .ACT_START(V_START), .ACT_END(V_START + V_ACTIVE - 1)
    ) u_v (
        .clk(clk), .rst(rst), .step(h_carry),
        .cnt(vcnt), .cnt_next(v_next), .sync_n(vsync), .carry(v_carry_unused),
        .active_next(v_act_next), .last_next(v_last_next)
    );

    always_comb begin
        h_off       = h_next - H_START_C;
        v_off       = v_next - V_START_C;
        de_d        = h_act_next && v_act_next;
        pix_x_d     = de_d ? h_off[PIX_W-1:0] : '0;
        pix_y_d     = de_d ? v_off[PIX_W-1:0] : '0;
        // Held (en=0) cycles must not repeat the strobe even when parked on the last count.
        frame_end_d = en && h_last_next && v_last_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q        <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            frame_end_q <= 1'b0;
        end else begin
            de_q        <= de_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign de        = de_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// tb/tb_tft_timing_gen.sv - self-checking bench for tft_timing_gen
// Instance 0 uses panel defaults, instance 1 a tiny raster so whole frames fit.
module tb_tft_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en;
    logic [9:0] hcnt0, vcnt0, hcnt1, vcnt1;
    logic [8:0] px0, py0, px1, py1;
    logic de0, hs0, vs0, fe0, de1, hs1, vs1, fe1;

    tft_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .en(en),
        .hcnt(hcnt0), .vcnt(vcnt0), .de(de0), .hsync(hs0), .vsync(vs0),
        .pix_x(px0), .pix_y(py0), .frame_end(fe0)
    );

    tft_timing_gen #(
        .H_SYNC(4), .H_BP(2), .H_ACTIVE(10), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(5), .V_FP(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .en(en),
        .hcnt(hcnt1), .vcnt(vcnt1), .de(de1), .hsync(hs1), .vsync(vs1),
        .pix_x(px1), .pix_y(py1), .frame_end(fe1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timing parameters per instance: sync, back porch, active, front porch.
    int p_hs[2] = '{41, 4};
    int p_hb[2] = '{3, 2};
    int p_ha[2] = '{480, 10};
    int p_hf[2] = '{1, 2};
    int p_vs[2] = '{10, 2};
    int p_vb[2] = '{3, 1};
    int p_va[2] = '{272, 5};
    int p_vf[2] = '{1, 1};

    int mh[2], mv[2];
    bit madv[2];
    bit model_on = 1'b0;

    // Model position: raster coordinates advanced once per enabled cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int ht, vt;
            ht = p_hs[i] + p_hb[i] + p_ha[i] + p_hf[i];
            vt = p_vs[i] + p_vb[i] + p_va[i] + p_vf[i];
            if (rst) begin
                mh[i] = 0; mv[i] = 0; madv[i] = 1'b0;
            end else if (en) begin
                madv[i] = 1'b1;
                if (mh[i] == ht - 1) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
                end else begin
                    mh[i] = mh[i] + 1;
                end
            end else begin
                madv[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < 2; i++) begin
                int ht, vt, hst, vst, e_de, e_px, e_py, e_hs, e_vs, e_fe;
                int a_h, a_v, a_de, a_hs, a_vs, a_px, a_py, a_fe;
                ht  = p_hs[i] + p_hb[i] + p_ha[i] + p_hf[i];
                vt  = p_vs[i] + p_vb[i] + p_va[i] + p_vf[i];
                hst = p_hs[i] + p_hb[i];
                vst = p_vs[i] + p_vb[i];
                e_de = (mh[i] >= hst && mh[i] < hst + p_ha[i] && mv[i] >= vst && mv[i] < vst + p_va[i]) ? 1 : 0;
                e_px = e_de ? mh[i] - hst : 0;
                e_py = e_de ? mv[i] - vst : 0;
                e_hs = (mh[i] < p_hs[i]) ? 0 : 1;
                e_vs = (mv[i] < p_vs[i]) ? 0 : 1;
                e_fe = (madv[i] && mh[i] == ht - 1 && mv[i] == vt - 1) ? 1 : 0;
                if (i == 0) begin
                    a_h = hcnt0; a_v = vcnt0; a_de = de0; a_hs = hs0; a_vs = vs0; a_px = px0; a_py = py0; a_fe = fe0;
                end else begin
                    a_h = hcnt1; a_v = vcnt1; a_de = de1; a_hs = hs1; a_vs = vs1; a_px = px1; a_py = py1; a_fe = fe1;
                end
                check($sformatf("model hcnt[%0d]", i), a_h, mh[i]);
                check($sformatf("model vcnt[%0d]", i), a_v, mv[i]);
                check($sformatf("model de[%0d]", i), a_de, e_de);
                check($sformatf("model hsync[%0d]", i), a_hs, e_hs);
                check($sformatf("model vsync[%0d]", i), a_vs, e_vs);
                check($sformatf("model pix_x[%0d]", i), a_px, e_px);
                check($sformatf("model pix_y[%0d]", i), a_py, e_py);
                check($sformatf("model frame_end[%0d]", i), a_fe, e_fe);
            end
        end
    end

    initial begin
        int h_before, cnt_hs, cnt_vs, cnt_de, cnt_box, bad_box, cnt_fe;
        bit done, seen_de, found;

        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        model_on = 1'b1;
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset hcnt0", hcnt0, 0);
        check("reset vcnt0", vcnt0, 0);
        check("reset hsync0", hs0, 0);
        check("reset vsync0", vs0, 0);
        check("reset de1", de1, 0);
        check("reset frame_end1", fe1, 0);

        rst = 1'b0;
        @(negedge clk);
        check("first en hcnt0", hcnt0, 1);
        check("first en hcnt1", hcnt1, 1);

        h_before = hcnt1;
        en = 1'b1; @(negedge clk);
        en = 1'b0; @(negedge clk);
        en = 1'b0; @(negedge clk);
        en = 1'b1; @(negedge clk);
        check("en 1001 advance", hcnt1 - h_before, 2);
        check("en 1001 hcnt0", hcnt0, 3);

        // Default raster: line 1 hsync, lines 1..9 vsync, first active line.
        cnt_hs = 0; cnt_vs = 0; cnt_de = 0; done = 1'b0; seen_de = 1'b0;
        for (int c = 0; c < 9000 && !done; c++) begin
            @(negedge clk);
            if (vcnt0 == 1 && !hs0) cnt_hs++;
            if (vcnt0 >= 1 && vcnt0 <= 9 && !vs0) cnt_vs++;
            if (de0) begin
                if (!seen_de) begin
                    seen_de = 1'b1;
                    check("first de hcnt", hcnt0, 44);
                    check("first de vcnt", vcnt0, 13);
                    check("first de pix_x", px0, 0);
                    check("first de pix_y", py0, 0);
                end
                cnt_de++;
                if (hcnt0 == 523) check("line end pix_x", px0, 479);
            end
            if (vcnt0 == 14) done = 1'b1;
        end
        check("default run done", done, 1);
        check("hsync low per line", cnt_hs, 41);
        check("vsync low lines 1..9", cnt_vs, 9 * 525);
        check("de per active line", cnt_de, 480);

        // Small raster: one full frame between frame_end strobes.
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (fe1) found = 1'b1;
        end
        check("frame_end seen", found, 1);
        check("frame_end hcnt", hcnt1, 17);
        check("frame_end vcnt", vcnt1, 8);
        cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_box = 0; bad_box = 0; cnt_fe = 0;
        for (int k = 1; k <= 162; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("after fe hcnt", hcnt1, 0);
                check("after fe vcnt", vcnt1, 0);
            end
            if (!hs1) cnt_hs++;
            if (!vs1) cnt_vs++;
            if (de1) cnt_de++;
            if (fe1) cnt_fe++;
            if (de1 && hcnt1 >= 8 && hcnt1 <= 10 && vcnt1 >= 4 && vcnt1 <= 5) begin
                cnt_box++;
                if (px1 < 2 || px1 > 4 || py1 < 1 || py1 > 2) bad_box++;
            end
        end
        check("fe period end", fe1, 1);
        check("fe pulses per frame", cnt_fe, 1);
        check("small hsync low", cnt_hs, 36);
        check("small vsync low", cnt_vs, 36);
        check("small de count", cnt_de, 50);
        check("box pixels", cnt_box, 6);
        check("box pix range", bad_box, 0);

        // Mid-frame reset while inside the active area.
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (de1 && hcnt1 == 9 && vcnt1 == 4) found = 1'b1;
        end
        check("midframe target", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst hcnt", hcnt1, 0);
        check("midrst vcnt", vcnt1, 0);
        check("midrst de", de1, 0);
        check("midrst hsync", hs1, 0);
        check("midrst vsync", vs1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("resume hcnt", hcnt1, 1);

        for (int c = 0; c < 4000; c++) begin
            en  = ($urandom % 4) != 0;
            rst = ($urandom % 500) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        model_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
